// File: rtl/fpnew_lane_div_iter_if.sv
// Lane divider handshake and data bundle between the aux FSM chain and the iterative divider.
interface fpnew_lane_div_iter_if #(
    parameter int MantWidth = 24
);
    logic                   flush_i;
    logic                   start_i;
    logic [MantWidth-1:0]   dividend_i;
    logic [MantWidth-1:0]   divisor_i;
    logic                   ready_o;
    logic [MantWidth+1:0]   quotient_o;
    logic                   sticky_o;

    modport master (
        output flush_i, start_i, dividend_i, divisor_i,
        input  ready_o, quotient_o, sticky_o
    );

    modport slave (
        input  flush_i, start_i, dividend_i, divisor_i,
        output ready_o, quotient_o, sticky_o
    );
endinterface

// File: rtl/fpnew_lane_div_iter.sv
// Iterative radix-2 restoring mantissa divider for one FPU lane.
// Define FPNEW_DIV_ITER_UNROLL2_EN to retire two quotient bits per cycle.
module fpnew_lane_div_iter #(
    parameter int MantWidth = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fpnew_lane_div_iter_if.slave  bus
);
    localparam int QuotWidth = MantWidth + 2;
`ifdef FPNEW_DIV_ITER_UNROLL2_EN
    localparam int NumIter = (QuotWidth + 1) / 2;
`else
    localparam int NumIter = QuotWidth;
`endif
    localparam int CntW = $clog2(NumIter + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]            state_q;
    logic [CntW-1:0]       cnt_q;
    logic [MantWidth:0]    rem_q;
    logic [MantWidth-1:0]  dsr_q;
    logic [QuotWidth-1:0]  quot_q;

    logic [MantWidth+1:0]  step_a;
    logic [MantWidth:0]    rem_d;
    logic [QuotWidth-1:0]  quot_d;

    // Returns {quotient bit, shifted partial remainder}.
    function automatic logic [MantWidth+1:0] div_step(
        input logic [MantWidth:0]   rem,
        input logic [MantWidth-1:0] dsr
    );
        logic signed [MantWidth+1:0] trial;
        logic                        q;
        logic [MantWidth:0]          r;
        trial = $signed({1'b0, rem}) - $signed({2'b00, dsr});
        q     = ~trial[MantWidth+1];
        r     = q ? trial[MantWidth:0] : rem;
        return {q, r[MantWidth-1:0], 1'b0};
    endfunction

`ifdef FPNEW_DIV_ITER_UNROLL2_EN
    logic [MantWidth+1:0]  step_b;

    always_comb begin
        step_a = div_step(rem_q, dsr_q);
        step_b = div_step(step_a[MantWidth:0], dsr_q);
        // Odd quotient widths leave a single bit for the last cycle.
        if ((QuotWidth % 2 == 1) && (cnt_q == CntW'(1))) begin
            rem_d  = step_a[MantWidth:0];
            quot_d = {quot_q[QuotWidth-2:0], step_a[MantWidth+1]};
        end else begin
            rem_d  = step_b[MantWidth:0];
            quot_d = {quot_q[QuotWidth-3:0], step_a[MantWidth+1], step_b[MantWidth+1]};
        end
    end
`else
    always_comb begin
        step_a = div_step(rem_q, dsr_q);
        rem_d  = step_a[MantWidth:0];
        quot_d = {quot_q[QuotWidth-2:0], step_a[MantWidth+1]};
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
        end else if (bus.flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (bus.start_i) begin
            state_q <= BUSY;
            cnt_q   <= CntW'(NumIter);
            rem_q   <= {1'b0, bus.dividend_i};
            quot_q  <= '0;
        end else if (state_q == BUSY) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                state_q <= IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (bus.start_i && !bus.flush_i && !rst_i) begin
            dsr_q <= bus.divisor_i;
        end
    end

    assign bus.ready_o    = (state_q == IDLE);
    assign bus.quotient_o = quot_q;
    assign bus.sticky_o   = |rem_q;
endmodule

// File: tb/tb_fpnew_lane_div_iter.sv
// Scoreboard bench for the lane divider: a 4-bit instance for directed/exhaustive cases, a 24-bit one for random.
module tb_fpnew_lane_div_iter;
`ifdef FPNEW_DIV_ITER_UNROLL2_EN
    localparam int NI4  = 3;
    localparam int NI24 = 13;
`else
    localparam int NI4  = 6;
    localparam int NI24 = 26;
`endif

    typedef struct {
        logic [25:0] q;
        logic        s;
        bit          skip;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpnew_lane_div_iter_if #(.MantWidth(4))  b4 ();
    fpnew_lane_div_iter_if #(.MantWidth(24)) b24 ();

    fpnew_lane_div_iter #(.MantWidth(4)) u4 (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (b4.slave)
    );

    fpnew_lane_div_iter #(.MantWidth(24)) u24 (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (b24.slave)
    );

    exp_t sb4[$];
    exp_t sb24[$];
    int   total = 0;
    int   bad   = 0;

    // Exact quotient of the scaled mantissa ratio, sticky from the division remainder.
    function automatic exp_t ref_div(input int m, input longint unsigned a, input longint unsigned b);
        exp_t e;
        longint unsigned n;
        n      = a << (m + 1);
        e.q    = 26'(n / b);
        e.s    = (n % b) != 0;
        e.skip = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitors: each ready rise pops one expectation; the low run must equal NumIter.
    exp_t e4, e24;
    int   low4 = 0, low24 = 0;
    logic pr4 = 1'b1, pr24 = 1'b1;

    always @(negedge clk) begin
        if (b4.ready_o === 1'b0) begin
            low4++;
        end else if (b4.ready_o === 1'b1 && pr4 === 1'b0) begin
            if (sb4.size() == 0) begin
                total++; bad++;
                $display("FAIL sb4_empty actual=completion required=none");
            end else begin
                e4 = sb4.pop_front();
                if (!e4.skip) begin
                    check("q4", 26'(b4.quotient_o), e4.q);
                    check("s4", 26'(b4.sticky_o), 26'(e4.s));
                    check("lat4", 26'(low4), 26'(NI4));
                end
            end
            low4 = 0;
        end
        pr4 = b4.ready_o;
    end

    always @(negedge clk) begin
        if (b24.ready_o === 1'b0) begin
            low24++;
        end else if (b24.ready_o === 1'b1 && pr24 === 1'b0) begin
            if (sb24.size() == 0) begin
                total++; bad++;
                $display("FAIL sb24_empty actual=completion required=none");
            end else begin
                e24 = sb24.pop_front();
                if (!e24.skip) begin
                    check("q24", b24.quotient_o, e24.q);
                    check("s24", 26'(b24.sticky_o), 26'(e24.s));
                    check("lat24", 26'(low24), 26'(NI24));
                end
            end
            low24 = 0;
        end
        pr24 = b24.ready_o;
    end

    task automatic start4(input logic [3:0] a, input logic [3:0] b);
        b4.dividend_i = a;
        b4.divisor_i  = b;
        b4.start_i    = 1'b1;
        sb4.push_back(ref_div(4, longint'(a), longint'(b)));
        @(posedge clk); #1;
        b4.start_i = 1'b0;
        check("busy4", 26'(b4.ready_o), 26'd0);
    endtask

    task automatic start24(input logic [23:0] a, input logic [23:0] b);
        b24.dividend_i = a;
        b24.divisor_i  = b;
        b24.start_i    = 1'b1;
        sb24.push_back(ref_div(24, longint'(a), longint'(b)));
        @(posedge clk); #1;
        b24.start_i = 1'b0;
    endtask

    task automatic wait4(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (b4.ready_o === 1'b1) break;
            @(posedge clk); #1;
        end
        if (i == budget) begin
            total++; bad++;
            $display("FAIL wait4 actual=timeout required=ready");
        end
    endtask

    task automatic wait24(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (b24.ready_o === 1'b1) break;
            @(posedge clk); #1;
        end
        if (i == budget) begin
            total++; bad++;
            $display("FAIL wait24 actual=timeout required=ready");
        end
    endtask

    initial begin
        rst = 1'b1;
        b4.flush_i = 1'b0;  b4.start_i = 1'b0;  b4.dividend_i = '0;  b4.divisor_i = '0;
        b24.flush_i = 1'b0; b24.start_i = 1'b0; b24.dividend_i = '0; b24.divisor_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready4", 26'(b4.ready_o), 26'd1);
        check("rst_q4", 26'(b4.quotient_o), 26'd0);
        check("rst_s4", 26'(b4.sticky_o), 26'd0);
        check("rst_ready24", 26'(b24.ready_o), 26'd1);
        check("rst_q24", b24.quotient_o, 26'd0);

        // 1.5 / 1.0, then hold without start
        start4(4'b1100, 4'b1000);
        wait4(40);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("hold_q4", 26'(b4.quotient_o), 26'b110000);
            check("hold_rdy4", 26'(b4.ready_o), 26'd1);
        end

        start4(4'b1000, 4'b1100);
        wait4(40);
        check("q_010101", 26'(b4.quotient_o), 26'b010101);
        check("s_010101", 26'(b4.sticky_o), 26'd1);

        // Back-to-back: second start on the first ready cycle
        start4(4'b1100, 4'b1000);
        wait4(40);
        start4(4'b1000, 4'b1000);
        wait4(40);
        check("b2b_q", 26'(b4.quotient_o), 26'b100000);

        // Flush two cycles after start, with a competing start
        start4(4'b1100, 4'b1000);
        @(posedge clk); #1;
        sb4[sb4.size()-1].skip = 1'b1;
        b4.flush_i    = 1'b1;
        b4.start_i    = 1'b1;
        b4.dividend_i = 4'b1111;
        b4.divisor_i  = 4'b1001;
        @(posedge clk); #1;
        b4.flush_i = 1'b0;
        b4.start_i = 1'b0;
        check("flush_rdy", 26'(b4.ready_o), 26'd1);
        @(posedge clk); #1;
        check("flush_idle", 26'(b4.ready_o), 26'd1);
        start4(4'b1000, 4'b1100);
        wait4(40);

        // Reset in the middle of a division
        start4(4'b1111, 4'b1001);
        repeat (2) @(posedge clk);
        #1;
        sb4[sb4.size()-1].skip = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_rdy", 26'(b4.ready_o), 26'd1);
        check("mid_rst_q", 26'(b4.quotient_o), 26'd0);
        check("mid_rst_s", 26'(b4.sticky_o), 26'd0);

        // All normalized 4-bit operand pairs, back-to-back
        for (int a = 8; a < 16; a++) begin
            for (int b = 8; b < 16; b++) begin
                start4(4'(a), 4'(b));
                wait4(40);
            end
        end

        // Random 24-bit operands with a few extremes up front
        for (int i = 0; i < 120; i++) begin
            logic [31:0] ra, rb;
            logic [23:0] a, b;
            ra = $urandom;
            rb = $urandom;
            a = {1'b1, ra[22:0]};
            b = {1'b1, rb[22:0]};
            if (i == 0) begin a = 24'hFFFFFF; b = 24'h800000; end
            if (i == 1) begin a = 24'h800000; b = 24'hFFFFFF; end
            if (i == 2) b = a;
            start24(a, b);
            wait24(100);
        end

        repeat (5) @(posedge clk);
        #1;
        check("sb4_drained", 26'(sb4.size()), 26'd0);
        check("sb24_drained", 26'(sb24.size()), 26'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
